instr_loader: RTL
=================

Name: instr_loader

Overview:
- Front-end stage that sits directly upstream of the CPU core.
- Turns a raw push-button and 8 DIP switches into complete 16-bit instructions: 4-bit opcode plus 12-bit operand field.
- Synchronizes and debounces the button, assembles each instruction from two presses, and buffers completed instructions in a small FIFO.
- Presents buffered instructions to the core over a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced level changes; range ≥2.
- FIFO_DEPTH, 4: instruction FIFO entries; must be a power of 2, ≥2.
- TIMEOUT_CYCLES, 65535: half-instruction abandon timeout; used only with INSTR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-high; clears all state.
- sw_in  in  8  DIP switch value, sampled on each accepted press.
- btn_raw  in  1  raw push-button level, asynchronous to clk.
- instr_valid  out  1  FIFO head holds a complete instruction.
- instr_ready  in  1  core accepts the head this cycle.
- opcode_out  out  4  head opcode.
- operand_out  out  12  head operand field.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held.
- half_pending  out  1  first byte captured, second byte awaited.
- overflow  out  1  sticky; a completed instruction was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0. FIFO empty, staging cleared, debounced level 0, debounce counter 0.
- Synchronizer: 2-flop chain on btn_raw; only the second flop output (sync) is used.
- Debounce:
  - When sync equals the debounced level, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, the debounced level takes sync and the counter clears.
  - Any bounce resets the count.
- Press pulse: 1-cycle registered pulse on each debounced 0→1 transition. Release (1→0) produces nothing.
- Assembly FSM, states IDLE and HALF:
  - IDLE + press: staging[7:0] <= sw_in; go to HALF; half_pending=1.
  - HALF + press: form word {sw_in, staging}. Opcode = staging[3:0]. Operand = {sw_in, staging[7:4]}, i.e. operand[3:0]=staging[7:4] and operand[11:4]=sw_in. Push the word; go to IDLE; half_pending=0.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped, overflow is set, and the FSM still returns to IDLE.
- FIFO:
  - First-word-fall-through: opcode_out/operand_out always reflect the head; they are 0 when empty.
  - instr_valid = (fifo_count != 0).
  - Pop when instr_valid && instr_ready.
  - instr_ready while empty has no effect.
- Simultaneous push and pop:
  - When full: both occur and the count is unchanged; no overflow.
  - When empty: push only. instr_valid rises the following cycle; there is no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH. fifo_count saturates exactly at FIFO_DEPTH.
- Latency: from btn_raw stable high to the press pulse is DEBOUNCE_CYCLES+3 cycles (±1 for metastability). The pushed word is visible on instr_valid one cycle after the press pulse.
- overflow clears only on rst.
- Reset mid-operation: pending half, FIFO contents and overflow are discarded. If the button is held through reset release, it is debounced from 0 and yields one press.

Optional Feature:
- Macro: INSTR_TIMEOUT_EN.
- Defined:
  - A counter runs while in HALF and clears on entry to HALF.
  - After TIMEOUT_CYCLES cycles in HALF with no press, the FSM returns to IDLE, the staged byte is discarded, and half_pending drops.
  - If a press and the timeout coincide in the same cycle, the press wins.
- Undefined: HALF persists indefinitely; no counter is synthesized.

Test Plan:
1. DEBOUNCE_CYCLES=16. Press with sw_in=8'hA3, release, press with sw_in=8'h5C, instr_ready=0 → instr_valid=1, opcode_out=4'h3, operand_out=12'h5CA, fifo_count=1, half_pending=0.
2. Bounce btn_raw high/low every 5 cycles for 100 cycles, then hold low → no press pulse; half_pending stays 0; fifo_count stays 0.
3. Load 5 instructions with FIFO_DEPTH=4 and instr_ready=0 → fifo_count=4, overflow=1, head is the 1st instruction. Then assert instr_ready for 4 cycles → instructions 1–4 drain in order, instr_valid=0.
4. FIFO full, instr_ready=1, and the second press completes in the same cycle → pop and push both occur; fifo_count stays 4; overflow stays 0; the new word sits at the tail.
5. Assert rst asynchronously mid-clock while in HALF with 2 entries buffered → all outputs 0 immediately. After release, a fresh two-press sequence produces a single correct instruction.
6. With INSTR_TIMEOUT_EN and TIMEOUT_CYCLES=100: one press, then wait 101 cycles → half_pending=0. A following two-press sequence yields opcode and operand from the new presses only.

Source files
------------

// File: rtl/instr_loader.sv
// Push-button instruction loader: synchronizes and debounces the button, assembles 16-bit words from two presses, and buffers them in a FWFT FIFO.
// Optional macro INSTR_TIMEOUT_EN abandons a half-entered instruction after TIMEOUT_CYCLES idle cycles.
module instr_loader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    sw_in,
    input  logic                          btn_raw,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [3:0]                    opcode_out,
    output logic [11:0]                   operand_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          half_pending,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HALF = 1'b1;

    logic          sync1_reg, sync2_reg;
    logic          db_level_reg;
    logic [DW-1:0] db_cnt_reg;
    logic          press_reg;
    logic [0:0]    state_reg;
    logic [7:0]    staging_reg;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    logic          full, pop, push, push_ok, timeout_hit;
    logic [15:0]   word, head;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign pop     = (count_reg != '0) && instr_ready;
    assign push    = press_reg && (state_reg == HALF);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign word    = {staging_reg[3:0], sw_in, staging_reg[7:4]};
    assign head    = mem[rd_ptr_reg];

    assign instr_valid  = (count_reg != '0);
    assign opcode_out   = instr_valid ? head[15:12] : 4'h0;
    assign operand_out  = instr_valid ? head[11:0] : 12'h000;
    assign fifo_count   = count_reg;
    assign half_pending = (state_reg == HALF);
    assign overflow     = overflow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            db_level_reg <= 1'b0;
            db_cnt_reg   <= '0;
            press_reg    <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == db_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_level_reg <= sync2_reg;
                db_cnt_reg   <= '0;
                press_reg    <= sync2_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

`ifdef INSTR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_reg <= '0;
        end else if (state_reg == HALF && !press_reg) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end else begin
            to_cnt_reg <= '0;
        end
    end

    // A press arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state_reg == HALF) && !press_reg &&
                         (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            staging_reg  <= 8'h00;
            overflow_reg <= 1'b0;
        end else begin
            if (press_reg) begin
                if (state_reg == IDLE) begin
                    staging_reg <= sw_in;
                    state_reg   <= HALF;
                end else begin
                    staging_reg <= 8'h00;
                    state_reg   <= IDLE;
                    if (!push_ok) begin
                        overflow_reg <= 1'b1;
                    end
                end
            end else if (timeout_hit) begin
                staging_reg <= 8'h00;
                state_reg   <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= word;
        end
    end
endmodule
